// File: rtl/bram_line_mover.sv
// -----------------------------------------------------------------------------
// bram_line_mover
//
// Moves one cache line between a streaming interface and one port of the
// dual-port data-array block RAM. The RAM has a 1-cycle registered read and
// returns zero when the port is not enabled.
//
//   Refill (req_wr=1): words arriving on wdata are written straight into the
//                      RAM at {index, offset}, offsets ascending from 0.
//   Evict  (req_wr=0): words are read from the RAM and streamed out on rdata
//                      through a 2-entry output FIFO with at most one read in
//                      flight, so back-pressure on rdata never loses a word.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    line request handshake; req_ready high only in IDLE
//   req_wr, req_index      request mode and line index
//   wdata_valid/ready,     refill word stream
//   wdata
//   rdata_valid/ready,     evict word stream; rdata_last marks the final word
//   rdata, rdata_last
//   done                   one-cycle completion pulse
//   bram_en, bram_we,      RAM port controls; bram_addr = {index, offset}
//   bram_addr, bram_din
//   bram_dout              RAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module bram_line_mover #(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 7,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic                                         req_wr,
    input  logic [ADDR_SIZE-$clog2(WORDS_PER_LINE)-1:0]  req_index,
    input  logic                                         wdata_valid,
    output logic                                         wdata_ready,
    input  logic [DATA_SIZE-1:0]                         wdata,
    output logic                                         rdata_valid,
    input  logic                                         rdata_ready,
    output logic [DATA_SIZE-1:0]                         rdata,
    output logic                                         rdata_last,
    output logic                                         done,
    output logic                                         bram_en,
    output logic [DATA_SIZE/8-1:0]                       bram_we,
    output logic [ADDR_SIZE-1:0]                         bram_addr,
    output logic [DATA_SIZE-1:0]                         bram_din,
    input  logic [DATA_SIZE-1:0]                         bram_dout
);

    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = ADDR_SIZE - OFF;
    localparam int BYTES = DATA_SIZE / 8;

    // Issue counter needs one extra bit so it can reach WORDS_PER_LINE.
    localparam logic [OFF:0]   WPL_CNT  = (OFF + 1)'(WORDS_PER_LINE);
    localparam logic [OFF-1:0] LAST_OFF = OFF'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               wr_q, wr_d;
    logic [OFF-1:0]     wcnt_q, wcnt_d;     // refill word offset
    logic [OFF:0]       icnt_q, icnt_d;     // evict reads issued
    logic [OFF-1:0]     acnt_q, acnt_d;     // evict words pushed into FIFO
    logic               pend_q, pend_d;     // read issued last cycle
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;

    logic [DATA_SIZE-1:0] fifo_data [2];
    logic                 fifo_last [2];

    // FSM control signals
    logic       accept;
    logic       wr_hs;
    logic       issue;
    logic       push;
    logic       pop;
    logic       head_last;
    logic       push_last;
    logic [2:0] occ_after;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            index_q    <= '0;
            wr_q       <= 1'b0;
            wcnt_q     <= '0;
            icnt_q     <= '0;
            acnt_q     <= '0;
            pend_q     <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            wr_q       <= wr_d;
            wcnt_q     <= wcnt_d;
            icnt_q     <= icnt_d;
            acnt_q     <= acnt_d;
            pend_q     <= pend_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO entries. Each entry is loaded from bram_dout when the
    // in-flight read returns and the write pointer selects it.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_SIZE-1:0] data_q, data_d;
            logic                 last_q, last_d;

            always_comb begin
                data_d = data_q;
                last_d = last_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d = bram_dout;
                    last_d = push_last;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    last_q <= last_d;
                end
            end

            assign fifo_data[gi] = data_q;
            assign fifo_last[gi] = last_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_hs && (wcnt_q == LAST_OFF)) begin
                    state_d = DONE;
                end
            end
            READ: begin
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / control logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready   = (state_q == IDLE);
        accept      = req_valid && (state_q == IDLE);

        // wr_q is redundant with the WRITE state but keeps the refill path
        // tied to the mode captured with the request.
        wdata_ready = (state_q == WRITE) && wr_q;
        wr_hs       = wdata_valid && wdata_ready;

        rdata_valid = (fifo_cnt_q != 2'd0);
        rdata       = rdata_valid ? fifo_data[rd_ptr_q] : '0;
        head_last   = fifo_last[rd_ptr_q];
        rdata_last  = rdata_valid && head_last;
        pop         = rdata_valid && rdata_ready;

        // The read issued last cycle returns now and always has room.
        push        = (state_q == READ) && pend_q;
        push_last   = (acnt_q == LAST_OFF);

        // Words held or in flight once this cycle's pop is taken out; a new
        // read only goes out if that leaves room for its return.
        occ_after   = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, pend_q};
        issue       = (state_q == READ) && (icnt_q < WPL_CNT) && (occ_after < 3'd2);

        done        = (state_q == DONE);

        bram_en     = 1'b0;
        bram_we     = '0;
        bram_addr   = '0;
        bram_din    = '0;
        if (wr_hs) begin
            bram_en   = 1'b1;
            bram_we   = {BYTES{1'b1}};
            bram_addr = {index_q, wcnt_q};
            bram_din  = wdata;
        end else if (issue) begin
            bram_en   = 1'b1;
            bram_addr = {index_q, icnt_q[OFF-1:0]};
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        index_d    = index_q;
        wr_d       = wr_q;
        wcnt_d     = wcnt_q;
        icnt_d     = icnt_q;
        acnt_d     = acnt_q;
        pend_d     = issue;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;

        if (accept) begin
            index_d = req_index;
            wr_d    = req_wr;
            wcnt_d  = '0;
            icnt_d  = '0;
            acnt_d  = '0;
        end

        if (wr_hs) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        if (issue) begin
            icnt_d = icnt_q + 1'b1;
        end

        if (push) begin
            acnt_d = acnt_q + 1'b1;
        end
    end

endmodule
